// File: rtl/uart_pkg.sv
// Shared UART types and constants for the telemetry path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } uart_tx_state_t;

  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

endpackage

// File: rtl/uart_baud_counter.sv
// Free-running bit-period counter; tick marks the last cycle of each bit.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TERM);

  // Wraps on its own at terminal count so no mid-frame clear is needed.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one byte in flight, registered tx/busy/tx_done.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_tx,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_done,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

  if (CLKS_PER_BIT < 2) begin : g_cpb_check
    $error("uart_tx: CLKS_PER_BIT must be >= 2");
  end

  uart_tx_state_t state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           tx_done_q, tx_done_d;
  logic           baud_clear, baud_tick;

  // Counter sits at zero whenever a new frame may be accepted.
  assign baud_clear = (state_q == IDLE) || (state_q == DONE);

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (baud_clear),
    .tick  (baud_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    tx_done_d = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        if (start_tx) begin
          state_d = START;
          shift_d = din;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: if (baud_tick) begin
        state_d   = DATA;
        bit_idx_d = 3'd0;
        tx_d      = shift_q[0];
      end
      DATA: if (baud_tick) begin
        shift_d = shift_q >> 1;
        if (bit_idx_q == 3'd7) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          bit_idx_d = bit_idx_q + 3'd1;
          // tx is registered, so present the bit that shifts into position 0.
          tx_d      = shift_q[1];
        end
      end
      STOP: if (baud_tick) begin
        state_d   = DONE;
        tx_d      = 1'b1;
        busy_d    = 1'b0;
        tx_done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at CPB=16 against a per-cycle frame model.
module tb_uart_tx;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_tx;
  logic [7:0] din;
  logic       tx, tx_done, busy;

  int checks   = 0;
  int failures = 0;

  uart_tx #(.CLK_FREQ_HZ(16), .BAUD_RATE(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .start_tx (start_tx),
    .din      (din),
    .tx       (tx),
    .tx_done  (tx_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Line level t cycles after the accepting edge (t = 1 .. FRAME).
  function automatic logic exp_line(input logic [7:0] b, input int t);
    int pos;
    pos = (t - 1) / CPB;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[3'(pos - 1)];
    return 1'b1;
  endfunction

  task automatic accept(input logic [7:0] b);
    din      = b;
    start_tx = 1'b1;
    step();
    start_tx = 1'b0;
  endtask

  task automatic expect_idle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
        failures++;
        $display("FAIL %s cycle %0d: tx=%b busy=%b tx_done=%b, want 1/0/0",
                 name, i, tx, busy, tx_done);
      end
      step();
    end
  endtask

  // Observes one whole frame after acceptance. mode: 0 plain, 1 din churn,
  // 2 extra start at cycle 40, 3 start_tx held high throughout.
  task automatic watch_frame(input string name, input logic [7:0] b,
                             input int mode, input logic [7:0] other,
                             input bit chain, input logic [7:0] nxt);
    logic [7:0] dec;
    logic       ex_tx, ex_busy, ex_done;
    int         p;
    dec = 8'h00;
    for (int t = 1; t <= FRAME + 1; t++) begin
      if (t <= FRAME) begin
        ex_tx = exp_line(b, t); ex_busy = 1'b1; ex_done = 1'b0;
      end else begin
        ex_tx = 1'b1; ex_busy = 1'b0; ex_done = 1'b1;
      end
      checks++;
      if (tx !== ex_tx || busy !== ex_busy || tx_done !== ex_done) begin
        failures++;
        $display("FAIL %s t=%0d: tx=%b busy=%b tx_done=%b, want %b/%b/%b",
                 name, t, tx, busy, tx_done, ex_tx, ex_busy, ex_done);
      end
      if (t % CPB == CPB / 2) begin
        p = t / CPB;
        if (p >= 1 && p <= 8) dec[3'(p - 1)] = tx;
      end
      if (mode == 1) din = 8'($urandom);
      if (mode == 2 && t == 40) begin start_tx = 1'b1; din = other; end
      if (mode == 3) start_tx = 1'b1;
      if (t == FRAME + 1 && chain) begin start_tx = 1'b1; din = nxt; end
      step();
      start_tx = 1'b0;
    end
    checks++;
    if (dec !== b) begin
      failures++;
      $display("FAIL %s decode: got %h, want %h", name, dec, b);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start_tx = 1'b1; din = 8'hC3;
    repeat (3) step();
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
      failures++;
      $display("FAIL reset: tx=%b busy=%b tx_done=%b, want 1/0/0", tx, busy, tx_done);
    end
    reset = 1'b0; start_tx = 1'b0;
    expect_idle("reset_idle", 5);
  endtask

  task automatic test_single_byte();
    accept(8'h41);
    watch_frame("single_41", 8'h41, 0, 8'h00, 1'b0, 8'h00);
    expect_idle("single_after", 20);
  endtask

  task automatic test_back_to_back();
    accept(8'h2C);
    watch_frame("b2b_2C", 8'h2C, 0, 8'h00, 1'b1, 8'h0D);
    watch_frame("b2b_0D", 8'h0D, 0, 8'h00, 1'b0, 8'h00);
    expect_idle("b2b_after", 10);
  endtask

  task automatic test_start_while_busy();
    accept(8'h0A);
    watch_frame("busy_0A", 8'h0A, 2, 8'hFF, 1'b0, 8'h00);
    expect_idle("busy_after", 3 * CPB);
  endtask

  task automatic test_din_churn();
    accept(8'hA5);
    watch_frame("churn_A5", 8'hA5, 1, 8'h00, 1'b0, 8'h00);
    expect_idle("churn_after", 5);
  endtask

  task automatic test_held_start();
    accept(8'h96);
    watch_frame("held_1", 8'h96, 3, 8'h00, 1'b1, 8'h96);
    watch_frame("held_2", 8'h96, 0, 8'h00, 1'b0, 8'h00);
    expect_idle("held_after", 5);
  endtask

  task automatic test_reset_mid_frame();
    accept(8'h3C);
    for (int t = 1; t < 70; t++) begin
      checks++;
      if (tx !== exp_line(8'h3C, t) || busy !== 1'b1) begin
        failures++;
        $display("FAIL abort_pre t=%0d: tx=%b busy=%b, want %b/1",
                 t, tx, busy, exp_line(8'h3C, t));
      end
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
      failures++;
      $display("FAIL abort: tx=%b busy=%b tx_done=%b, want 1/0/0", tx, busy, tx_done);
    end
    expect_idle("abort_after", FRAME);
    accept(8'h55);
    watch_frame("after_abort_55", 8'h55, 0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic test_random();
    logic [7:0] b, nb;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      expect_idle("rand_gap", int'($urandom_range(0, 5)));
      accept(b);
      watch_frame("rand", b, 0, 8'h00, 1'b0, 8'h00);
    end
    b = 8'($urandom);
    accept(b);
    for (int i = 0; i < 3; i++) begin
      nb = 8'($urandom);
      watch_frame("rand_chain", b, 0, 8'h00, 1'b1, nb);
      b = nb;
    end
    watch_frame("rand_chain_last", b, 0, 8'h00, 1'b0, 8'h00);
    expect_idle("rand_after", 5);
  endtask

  initial begin
    reset = 1'b1; start_tx = 1'b0; din = 8'h00;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_start_while_busy();
    test_din_churn();
    test_held_start();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the telemetry path: accepts one byte per start request from the hex/CSV formatting FSM and shifts it onto the UART TX pin as a standard 8N1 frame. It sits directly downstream of the data formatting FSM, which drives `start_tx`/`din` and waits on `tx_done`. The block has no internal buffering, so exactly one byte is in flight at a time.

## Interface
Parameters:
- `CLK_FREQ_HZ`, default 100_000_000: system clock frequency.
- `BAUD_RATE`, default 115_200: line rate.
- Derived localparam `CLKS_PER_BIT` = `CLK_FREQ_HZ / BAUD_RATE`, using truncating integer division. Elaboration `$error` if < 2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `start_tx`  in  1  request to send `din`. Sampled on the rising edge; honoured only when idle.
- `din`  in  8  byte to send. Captured on the accepting edge.
- `tx`  out  1  serial line; idles high.
- `tx_done`  out  1  one-cycle pulse when a frame completes.
- `busy`  out  1  high while a frame is in progress.

## Operation
- Frame format:
  - Start bit (0), then `din[0]` through `din[7]` LSB first, then one stop bit (1).
  - Each bit is held for exactly `CLKS_PER_BIT` cycles.
- State machine: `IDLE` → `START` → `DATA` → `STOP` → `DONE` → `IDLE`.
  - `IDLE`: `tx`=1, `busy`=0. If `start_tx`=1, latch `din` into the shift register, clear the baud counter, and go to `START`.
  - `START`: `tx`=0. When the baud counter reaches `CLKS_PER_BIT-1`, clear it and go to `DATA` with the bit index at 0.
  - `DATA`: `tx` = shift_reg[0]. At counter terminal count, shift right and increment the bit index. After bit index 7, go to `STOP`.
  - `STOP`: `tx`=1. At terminal count, go to `DONE`.
  - `DONE`: `tx`=1, `tx_done`=1, `busy`=0. Unconditionally return to `IDLE`. `start_tx` in this cycle is accepted exactly as in `IDLE`, going straight to `START`.
- Width rules:
  - Baud counter is `$clog2(CLKS_PER_BIT)` bits and never exceeds `CLKS_PER_BIT-1`.
  - Bit index is 3 bits and does not wrap mid-frame.
- `start_tx` while `busy`=1 is ignored: no queueing, no error flag, and the frame in flight is unaffected.
- Changes on `din` after capture have no effect on the current frame.
- `tx`, `busy` and `tx_done` are all registered; `tx` is glitch-free.

## Timing
- Reset values: `tx`=1, `busy`=0, `tx_done`=0, state `IDLE`, counters 0, shift register 0.
- Reset asserted mid-frame: on the next edge `tx`=1 and `busy`=0. No `tx_done` pulse is produced for the aborted frame.
- Start accepted on edge N:
  - `busy`=1 and `tx`=0 from cycle N+1.
  - Data bit k is on the line for cycles N+1+(k+1)·CPB through N+(k+2)·CPB.
  - Stop bit occupies cycles N+1+9·CPB through N+10·CPB.
  - `tx_done`=1 for exactly cycle N+10·CPB+1.
- Back-to-back throughput: the earliest next accept is on the `tx_done` cycle, giving a byte period of 10·CPB+1 cycles.
- Upstream contract: the formatting FSM pulses `start_tx` for one cycle and waits for `tx_done`. A `start_tx` held high for multiple cycles starts a new frame on the first idle/`DONE` edge.

## Structure
- Shared package `uart_pkg`:
  - `uart_tx_state_t` enum.
  - ASCII constants `ASCII_COMMA`=8'h2C, `ASCII_CR`=8'h0D, `ASCII_LF`=8'h0A, also used by the formatting FSM.
- One natural sub-module: `uart_baud_counter`, parameterised by `CLKS_PER_BIT`.
  - Inputs: `clk`, `reset`, `clear`.
  - Output: `tick` at terminal count.
  - Everything else lives in `uart_tx`.

## Test plan
Benches use `CLK_FREQ_HZ`=16, `BAUD_RATE`=1, giving CPB=16.
- **Single byte:** `din`=8'h41 with a 1-cycle `start_tx` at edge N → `tx` sampled mid-bit reads 0,1,0,0,0,0,0,1,0,1. `tx_done` high only at N+161; `busy` high N+1 through N+160.
- **Back-to-back:** send 8'h2C; assert `start_tx` with 8'h0D on the `tx_done` cycle → second start bit begins the next cycle, no idle gap. Decoded bytes are 2C then 0D.
- **Start while busy:** pulse `start_tx` with 8'hFF at N+40 during an 8'h0A frame → line carries only 0A, and exactly one `tx_done`.
- **`din` churn:** randomise `din` every cycle after acceptance of 8'hA5 → decoded byte is A5.
- **Reset mid-frame:** assert `reset` at N+70 → `tx`=1 and `busy`=0 next edge, no `tx_done`. A subsequent 8'h55 frame is sent correctly.
- **Integration:** connect the formatting FSM, FIFO holding 32'h0000_BEEF → line decodes "0000BEEF\r\n" and the FIFO ends empty.
